// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port CHIP-8 memory between the ROM/font loader (LD),
// the CPU core and the sprite fetcher (GPU). LD has fixed priority; CPU/GPU alternate.
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,

    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic              gpu_gnt,
    output logic              gpu_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic {
        RR_CPU = 1'b0,
        RR_GPU = 1'b1
    } rr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_LD  = 2'd1,
        ST_RD_CPU = 2'd2,
        ST_RD_GPU = 2'd3
    } pend_t;

    rr_t   r_rr;
    pend_t r_pend;

    logic              w_sel_ld;
    logic              w_sel_cpu;
    logic              w_sel_gpu;
    logic              w_any_sel;
    logic              w_take;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    pend_t             w_pend_nxt;
    rr_t               w_rr_nxt;

    // LD always wins; CPU/GPU only consult the pointer when both are asking.
    assign w_sel_ld  = ld_req;
    assign w_sel_cpu = ~ld_req & cpu_req & (~gpu_req | (r_rr == RR_CPU));
    assign w_sel_gpu = ~ld_req & gpu_req & (~cpu_req | (r_rr == RR_GPU));
    assign w_any_sel = w_sel_ld | w_sel_cpu | w_sel_gpu;

    // NOTE: every signal written in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        if (w_sel_ld) begin
            w_sel_we    = ld_we;
            w_sel_addr  = ld_addr;
            w_sel_wdata = ld_wdata;
        end else if (w_sel_cpu) begin
            w_sel_we    = cpu_we;
            w_sel_addr  = cpu_addr;
            w_sel_wdata = cpu_wdata;
        end else if (w_sel_gpu) begin
            w_sel_addr  = gpu_addr;
        end
    end

    // Selection keeps steering the address during reset; only the strobes are gated.
    assign w_take  = w_any_sel & ~rst;
    assign ld_gnt  = w_sel_ld  & ~rst;
    assign cpu_gnt = w_sel_cpu & ~rst;
    assign gpu_gnt = w_sel_gpu & ~rst;

    assign mem_read       = w_take & ~w_sel_we;
    assign mem_write      = w_take &  w_sel_we;
    assign mem_read_addr  = w_sel_addr;
    assign mem_write_addr = w_sel_addr;
    assign mem_write_data = w_sel_wdata;
    assign rdata          = mem_read_data;

    always_comb begin
        w_pend_nxt = ST_IDLE;
        if (mem_read) begin
            if (ld_gnt) begin
                w_pend_nxt = ST_RD_LD;
            end else if (cpu_gnt) begin
                w_pend_nxt = ST_RD_CPU;
            end else begin
                w_pend_nxt = ST_RD_GPU;
            end
        end

        w_rr_nxt = r_rr;
        if (cpu_gnt) begin
            w_rr_nxt = RR_GPU;
        end else if (gpu_gnt) begin
            w_rr_nxt = RR_CPU;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr   <= RR_CPU;
            r_pend <= ST_IDLE;
        end else begin
            r_rr   <= w_rr_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    assign ld_rvalid  = (r_pend == ST_RD_LD);
    assign cpu_rvalid = (r_pend == ST_RD_CPU);
    assign gpu_rvalid = (r_pend == ST_RD_GPU);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: memory model, behavioural arbitration model with a read
// scoreboard, directed scenarios followed by randomized request traffic.
module tb_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_req, ld_we, cpu_req, cpu_we, gpu_req;
    logic [ADDR_W-1:0] ld_addr, cpu_addr, gpu_addr;
    logic [DATA_W-1:0] ld_wdata, cpu_wdata;
    logic              ld_gnt, cpu_gnt, gpu_gnt;
    logic              ld_rvalid, cpu_rvalid, gpu_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_read_addr, mem_write_addr;
    logic [DATA_W-1:0] mem_write_data, mem_read_data;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr),
        .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid),
        .rdata(rdata),
        .mem_read(mem_read), .mem_read_addr(mem_read_addr),
        .mem_write(mem_write), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {P_NONE, P_LD, P_CPU, P_GPU} port_e;
    typedef struct {
        port_e      port;
        logic [7:0] data;
        int         due;
    } rd_t;

    rd_t        sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] phys_mem [0:4095];
    logic [7:0] ref_mem  [0:4095];

    logic [2:0] s_g;
    logic [2:0] s_rv;
    logic [7:0] s_rd;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(int a);
        case (a)
            'h010:                 return 8'h11;
            'h020:                 return 8'h22;
            'h050, 'h054:          return 8'hF0;
            'h051, 'h052, 'h053:   return 8'h90;
            default:               return 8'((a * 37 + 11) & 255);
        endcase
    endfunction

    function automatic logic [2:0] onehot(port_e p);
        case (p)
            P_LD:    return 3'b100;
            P_CPU:   return 3'b010;
            P_GPU:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Single-port memory: read data appears the cycle after the strobe is sampled.
    initial begin
        for (int a = 0; a < 4096; a++) phys_mem[a] = init_byte(a);
        forever begin
            @(posedge clk);
            if (mem_write) phys_mem[mem_write_addr] <= mem_write_data;
            if (mem_read)  mem_read_data <= phys_mem[mem_read_addr];
        end
    end

    // Reference model: decides who should win from the arbitration rules, tracks memory
    // contents, and queues the expected read responses.
    initial begin : model
        port_e       win;
        port_e       fav;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wd;
        fav = P_CPU;
        for (int a = 0; a < 4096; a++) ref_mem[a] = init_byte(a);
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                sb_q.delete();
                fav = P_CPU;
                if (!clk) begin
                    check("rst_gnt", 32'({ld_gnt, cpu_gnt, gpu_gnt}), 32'd0);
                    check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
                end
            end else begin
                if (ld_req)                  win = P_LD;
                else if (cpu_req && gpu_req) win = fav;
                else if (cpu_req)            win = P_CPU;
                else if (gpu_req)            win = P_GPU;
                else                         win = P_NONE;

                we = 1'b0; addr = '0; wd = '0;
                case (win)
                    P_LD:    begin we = ld_we;  addr = ld_addr;  wd = ld_wdata;  end
                    P_CPU:   begin we = cpu_we; addr = cpu_addr; wd = cpu_wdata; end
                    P_GPU:   addr = gpu_addr;
                    default: ;
                endcase

                check("gnt", 32'({ld_gnt, cpu_gnt, gpu_gnt}), 32'(onehot(win)));
                check("mem_write", 32'(mem_write), 32'((win != P_NONE) && we));
                check("mem_read", 32'(mem_read), 32'((win != P_NONE) && !we));
                check("mem_read_addr", 32'(mem_read_addr), 32'(addr));
                check("mem_write_addr", 32'(mem_write_addr), 32'(addr));
                if ((win != P_NONE) && we) check("mem_write_data", 32'(mem_write_data), 32'(wd));

                if (win != P_NONE) begin
                    if (we) ref_mem[addr] = wd;
                    else    sb_q.push_back('{win, ref_mem[addr], cyc + 1});
                end
                if (win == P_CPU)      fav = P_GPU;
                else if (win == P_GPU) fav = P_CPU;
            end
        end
    end

    // Monitor: every cycle compares the rvalid strobes and rdata against the queue head.
    initial begin : monitor
        rd_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                check("rvalid_late", 32'(cyc), 32'(sb_q[0].due));
                void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                check("rvalid", 32'({ld_rvalid, cpu_rvalid, gpu_rvalid}), 32'(onehot(e.port)));
                check("rdata", 32'(rdata), 32'(e.data));
            end else begin
                check("rvalid_idle", 32'({ld_rvalid, cpu_rvalid, gpu_rvalid}), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not terminate in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
        s_g  = {ld_gnt, cpu_gnt, gpu_gnt};
        s_rv = {ld_rvalid, cpu_rvalid, gpu_rvalid};
        s_rd = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic drop_granted();
        if (s_g[2]) ld_req  = 1'b0;
        if (s_g[1]) cpu_req = 1'b0;
        if (s_g[0]) gpu_req = 1'b0;
    endtask

    initial begin : driver
        int         n_ld;
        int         n_oth;
        logic [2:0] prev;
        logic [7:0] font [0:4];
        font[0] = 8'hF0; font[1] = 8'h90; font[2] = 8'h90; font[3] = 8'h90; font[4] = 8'hF0;

        rst = 1'b1;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        gpu_req = 1'b0; gpu_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset.
        repeat (3) begin
            step();
            check("idle_gnt", 32'(s_g), 32'd0);
            check("idle_rvalid", 32'(s_rv), 32'd0);
        end

        // Loader holds its request: CPU and GPU starve, then CPU goes first.
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'h300;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h301;
        gpu_req = 1'b1; gpu_addr = 12'h302;
        n_ld = 0; n_oth = 0;
        repeat (10) begin
            step();
            if (s_g == 3'b100) n_ld++;
            else               n_oth++;
        end
        check("ld_hold_gnts", 32'(n_ld), 32'd10);
        check("ld_hold_others", 32'(n_oth), 32'd0);
        ld_req = 1'b0;
        step();
        check("after_ld_first", 32'(s_g), 32'b010);
        drop_granted();
        step();
        check("after_ld_second", 32'(s_g), 32'b001);
        drop_granted();

        // LD write then CPU read of the same address returns the new byte.
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'h200; ld_wdata = 8'hA5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
        step();
        check("raw_ld_first", 32'(s_g), 32'b100);
        drop_granted();
        step();
        check("raw_cpu_second", 32'(s_g), 32'b010);
        drop_granted();
        step();
        check("raw_rvalid", 32'(s_rv), 32'b010);
        check("raw_rdata", 32'(s_rd), 32'hA5);

        // CPU and GPU contend continuously: grants and responses alternate.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
        gpu_req = 1'b1; gpu_addr = 12'h020;
        step();
        prev = s_g;
        for (int i = 1; i < 8; i++) begin
            step();
            check("alt_gnt", 32'(s_g), 32'((prev == 3'b010) ? 3'b001 : 3'b010));
            check("alt_rvalid", 32'(s_rv), 32'(prev));
            check("alt_rdata", 32'(s_rd), 32'((prev == 3'b010) ? 8'h11 : 8'h22));
            prev = s_g;
        end
        cpu_req = 1'b0; gpu_req = 1'b0;
        step();

        // GPU alone streams five font bytes back to back.
        gpu_req = 1'b1; gpu_addr = 12'h050;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 5) begin
                check("font_gnt", 32'(s_g), 32'b001);
                gpu_addr = gpu_addr + 12'd1;
                if (i == 4) gpu_req = 1'b0;
            end
            if (i > 0) begin
                check("font_rvalid", 32'(s_rv), 32'b001);
                check("font_rdata", 32'(s_rd), 32'(font[i-1]));
            end
        end

        // Reset pulse after a CPU read is captured: no response, pointer back to CPU.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        step();
        check("rst_cpu_gnt", 32'(s_g), 32'b010);
        cpu_req = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        step();
        check("rst_no_rvalid", 32'(s_rv), 32'd0);
        cpu_req = 1'b1; cpu_addr = 12'h124;
        gpu_req = 1'b1; gpu_addr = 12'h125;
        step();
        check("rst_rr_cpu", 32'(s_g), 32'b010);
        drop_granted();
        step();
        drop_granted();

        // Randomized traffic over a small address window to provoke same-address hazards.
        for (int i = 0; i < 2000; i++) begin
            if (!ld_req && $urandom_range(7) == 0) begin
                ld_req = 1'b1; ld_we = 1'($urandom_range(1));
                ld_addr = 12'($urandom_range(31)); ld_wdata = 8'($urandom);
            end
            if (!cpu_req && $urandom_range(1) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
                cpu_addr = 12'($urandom_range(31)); cpu_wdata = 8'($urandom);
            end
            if (!gpu_req && $urandom_range(1) == 0) begin
                gpu_req = 1'b1; gpu_addr = 12'($urandom_range(31));
            end
            step();
            drop_granted();
        end
        ld_req = 1'b0; cpu_req = 1'b0; gpu_req = 1'b0;
        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 4 KiB CHIP-8 `memory` block between three requesters: the ROM/font loader (LD), the CPU core (CPU) and the display sprite fetcher (GPU).
- Grants at most one access per cycle and steers the memory read/write strobes, address and data.
- Returns read data with a per-port valid pulse.
- Sits between the requesters and `memory` in the top level.

Parameters:
- ADDR_W, 12, address width (4096 bytes).
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_req / cpu_req / gpu_req  in  1 each  access request; held until granted.
- ld_we / cpu_we  in  1 each  1 = write, 0 = read. GPU has no write port and is read-only.
- ld_addr / cpu_addr / gpu_addr  in  ADDR_W each  byte address.
- ld_wdata / cpu_wdata  in  DATA_W each  write data.
- ld_gnt / cpu_gnt / gpu_gnt  out  1 each  combinational grant, this cycle's access is taken.
- ld_rvalid / cpu_rvalid / gpu_rvalid  out  1 each  registered, read data valid this cycle.
- rdata  out  DATA_W  shared read data, wired straight from mem_read_data.
- mem_read  out  1  to memory.read.
- mem_read_addr  out  ADDR_W  to memory.read_addr.
- mem_write  out  1  to memory.write.
- mem_write_addr  out  ADDR_W  to memory.write_addr.
- mem_write_data  out  DATA_W  to memory.write_data.
- mem_read_data  in  DATA_W  from memory.read_data, valid the cycle after the read strobe is sampled.

Behaviour:
- Reset (async, rst=1):
  - all *_rvalid = 0.
  - Round-robin pointer rr = CPU.
  - Any in-flight read is dropped, with no rvalid after reset releases.
  - Combinational outputs follow the current requests even during reset, but mem_read and mem_write are forced to 0 and all gnt to 0 while rst=1.
- Arbitration, combinational each cycle:
  - LD has absolute priority.
  - If ld_req=0, CPU and GPU share round-robin: rr names the favoured port.
  - If only one of them requests, it wins regardless of rr.
  - Exactly one gnt is high, or none if no request.
- Round-robin pointer update:
  - On a CPU or GPU grant, rr moves to the other port.
  - rr is unchanged on LD grants and idle cycles.
- Memory drive:
  - Winner's address goes to both mem_read_addr and mem_write_addr.
  - mem_write = gnt & we, with mem_write_data = winner's wdata.
  - mem_read = gnt & ~we.
  - When idle: mem_read = mem_write = 0 and addresses = 0.
- Read latency:
  - A read granted in cycle N produces <port>_rvalid=1 for exactly cycle N+1.
  - rdata is valid in that cycle.
  - Tracking is one registered "pending port" field, states IDLE / RD_LD / RD_CPU / RD_GPU.
  - A new grant in cycle N+1 is allowed; back-to-back reads give rvalid on consecutive cycles.
- Writes produce no rvalid.
- Starvation: a requester may keep req high after gnt to issue the next access.
  - A continuous ld_req starves CPU and GPU. This is intended, because the loader runs only before CPU release.
  - CPU/GPU mutual starvation is impossible: with both requesting continuously, grants alternate.
- Ordering: a write granted in cycle N followed by a read of the same address granted in cycle N+1, from any port, returns the new data.
- Address out of range cannot occur, since ADDR_W covers the full space and there is no wrap logic.

Test Plan:
- Reset then idle, no requests → all gnt/rvalid 0, mem_read = mem_write = 0.
- LD writes 0xA5 @0x200 while cpu_req reads 0x200 → cycle 0 ld_gnt only with mem_write=1; cycle 1 cpu_gnt; cycle 2 cpu_rvalid=1 with rdata=0xA5.
- CPU and GPU request continuously, reads of 0x010 and 0x020 (preloaded 0x11 and 0x22), over 8 cycles after reset → grants CPU, GPU, CPU, GPU…; rvalid alternates one cycle later, rdata alternates 0x11/0x22.
- GPU alone reads 0x050–0x054 back-to-back (font bytes 0xF0, 0x90, 0x90, 0x90, 0xF0) → gpu_gnt 5 consecutive cycles, gpu_rvalid the following 5 cycles with those values.
- CPU read granted, rst pulsed asynchronously mid-cycle before next edge → no cpu_rvalid; rr back to CPU (CPU wins next tie).
- ld_req held 10 cycles with cpu_req and gpu_req also held → 10 ld_gnt cycles, zero cpu_gnt/gpu_gnt; then CPU is granted first.
